multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter: PC_W, default 7, program-counter width, legal range 1..8.
REQ-002 Parameter: RESET_VEC, default 0, PC value loaded on reset, width PC_W.
REQ-003 Port: Clock  in  1  sole clock, rising-edge.
REQ-004 Port: Reset  in  1  synchronous, active-high reset.
REQ-005 Port: IMem_req  out  1  instruction fetch request.
REQ-006 Port: IMem_addr  out  PC_W  fetch address, equal to PC.
REQ-007 Port: IMem_data  in  16  fetched instruction.
REQ-008 Port: IMem_valid  in  1  IMem_data valid this cycle.
REQ-009 Port: ALU_zero  in  1  ALU result equals zero.
REQ-010 Port: D_addr  out  8  data-memory address.
REQ-011 Port: D_wr  out  1  data-memory write enable.
REQ-012 Port: RF_s  out  1  register-file write mux (1 = data memory, 0 = ALU).
REQ-013 Port: RF_W_addr / RF_Ra_addr / RF_Rb_addr  out  4 each  register-file write and read addresses.
REQ-014 Port: RF_W_en  out  1  register-file write enable.
REQ-015 Port: ALU_s0  out  3  ALU operation select.
REQ-016 Port: PC_out  out  PC_W  current PC.
REQ-017 Port: IROut  out  16  instruction register.
REQ-018 Port: CurrentStateOut / NextStateOut  out  4 each  FSM state encodings.
REQ-019 Port: Halted  out  1  core stopped.
REQ-020 Port: IllegalOp  out  1  sticky flag set by an undefined opcode.

Function
REQ-021 The opcode SHALL be IR[15:12]. Encodings:
  - 0 NOOP
  - 1 LOAD: D_addr=IR[11:4], Rd=IR[3:0]
  - 2 STORE: D_addr=IR[11:4], Ra=IR[3:0]
  - 3..7 ALU ops: Ra=IR[11:8], Rb=IR[7:4], Rd=IR[3:0]; ALU_s0 = opcode-2 (3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR)
  - 8 JMP: target=IR[7:0]
  - 9 BRZ: Ra=IR[11:8], target=IR[7:0]
  - 15 HALT
  - all others illegal
REQ-022 States SHALL be INIT=0, FETCH=1, DECODE=2, LOAD_A=3, LOAD_B=4, STORE=5, ALU=6, JUMP=7, BRZ_EVAL=8, HALT=9.
REQ-023 INIT SHALL proceed to FETCH after one cycle.
REQ-024 In FETCH, IMem_req SHALL be 1. On the cycle IMem_valid=1, IR SHALL load IMem_data, PC SHALL increment, and the FSM SHALL move to DECODE. Otherwise it SHALL stay in FETCH with no timeout.
REQ-025 IMem_valid SHALL be ignored in every state other than FETCH.
REQ-026 DECODE SHALL branch on opcode:
  - NOOP -> FETCH
  - LOAD -> LOAD_A
  - STORE -> STORE
  - ALU ops -> ALU
  - JMP -> JUMP
  - BRZ -> BRZ_EVAL
  - HALT or illegal -> HALT (illegal also sets IllegalOp)
REQ-027 LOAD_A SHALL drive D_addr and RF_s=1. LOAD_B SHALL additionally drive RF_W_en=1 and RF_W_addr=Rd. Both SHALL then proceed -> FETCH.
REQ-028 STORE SHALL drive D_addr, RF_Ra_addr=Ra and D_wr=1 for exactly one cycle, then -> FETCH.
REQ-029 ALU SHALL drive Ra, Rb, ALU_s0, RF_s=0, RF_W_en=1 and RF_W_addr=Rd for one cycle, then -> FETCH.
REQ-030 JUMP SHALL load PC with target[PC_W-1:0], then -> FETCH.
REQ-031 BRZ_EVAL SHALL drive RF_Ra_addr=Ra and ALU_s0=0 (pass A). If ALU_zero=1, PC SHALL load the target; otherwise PC SHALL be unchanged. Either way the next state SHALL be FETCH.
REQ-032 Incrementing PC SHALL wrap from 2^PC_W-1 to 0. Target bits above PC_W SHALL be discarded.
REQ-033 HALT SHALL be absorbing with Halted=1. Only Reset SHALL exit it.
REQ-034 In any state not listed as asserting them, D_wr, RF_W_en and IMem_req SHALL be 0.
REQ-035 NextStateOut SHALL be the combinational next state. CurrentStateOut SHALL be the registered state.

Reset
REQ-036 While Reset=1 at a clock edge, the following SHALL hold at the next cycle:
  - state=INIT
  - PC=RESET_VEC
  - IR=0
  - IllegalOp=0, Halted=0
  - all enables 0
REQ-037 Reset SHALL take priority over every transition, including mid-FETCH. A concurrent IMem_valid SHALL be discarded.

Structure
REQ-038 The opcode and state enumerations SHALL live in the shared package controller_pkg.
REQ-039 The PC SHALL be a separate sub-module pc_counter, parameterised by PC_W, with load, increment and reset-vector inputs.

Verification
REQ-040 Reset=1 for 2 cycles, then release:
  - during reset: CurrentStateOut=0 and PC_out=0
  - one cycle after release: IMem_req=1
REQ-041 Fetch 0x3123 with IMem_valid delayed 3 cycles:
  - FSM remains in FETCH for 3 cycles
  - then ALU cycle with Ra=1, Rb=2, RF_W_addr=3, ALU_s0=1, RF_W_en=1
REQ-042 LOAD 0x1A57 -> D_addr=0xA5 and RF_s=1 for two cycles; RF_W_en=1 only in the second, with RF_W_addr=7.
REQ-043 BRZ 0x9240:
  - ALU_zero=1 -> PC_out=0x40
  - ALU_zero=0 -> PC_out = previous PC+1
REQ-044 PC=127 (PC_W=7) fetches NOOP -> PC_out=0. JMP 0xFF -> PC_out=0x7F.
REQ-045 Opcode 0xA -> IllegalOp=1 and Halted=1, and IMem_req stays 0 thereafter. A subsequent Reset clears both.

Source files
------------

// File: rtl/controller_pkg.sv
// Shared state and opcode encodings for the multicycle controller.
package controller_pkg;

  typedef enum logic [3:0] {
    ST_INIT     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_LOAD_A   = 4'd3,
    ST_LOAD_B   = 4'd4,
    ST_STORE    = 4'd5,
    ST_ALU      = 4'd6,
    ST_JUMP     = 4'd7,
    ST_BRZ_EVAL = 4'd8,
    ST_HALT     = 4'd9
  } state_e;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'd0,
    OP_LOAD  = 4'd1,
    OP_STORE = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_AND   = 4'd5,
    OP_OR    = 4'd6,
    OP_XOR   = 4'd7,
    OP_JMP   = 4'd8,
    OP_BRZ   = 4'd9,
    OP_HALT  = 4'd15
  } opcode_e;

  // ALU select for register-register ops is the opcode offset by two.
  function automatic logic [2:0] alu_sel(input logic [3:0] op);
    logic [3:0] d;
    d = op - 4'd2;
    return d[2:0];
  endfunction

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_NOOP, OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_JMP, OP_BRZ, OP_HALT: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: reset vector, parallel load, wrap-around increment.
module pc_counter #(
  parameter int unsigned PC_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] reset_vec,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  // Reset dominates load, load dominates increment; increment wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)       pc <= reset_vec;
    else if (load) pc <= load_val;
    else if (inc)  pc <= pc + 1'b1;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle instruction controller: fetch/decode/execute FSM driving
// register-file, ALU and data-memory control with registered outputs.
module multicycle_controller
  import controller_pkg::*;
#(
  parameter int unsigned     PC_W      = 7,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input  logic            Clock,
  input  logic            Reset,
  output logic            IMem_req,
  output logic [PC_W-1:0] IMem_addr,
  input  logic [15:0]     IMem_data,
  input  logic            IMem_valid,
  input  logic            ALU_zero,
  output logic [7:0]      D_addr,
  output logic            D_wr,
  output logic            RF_s,
  output logic [3:0]      RF_W_addr,
  output logic [3:0]      RF_Ra_addr,
  output logic [3:0]      RF_Rb_addr,
  output logic            RF_W_en,
  output logic [2:0]      ALU_s0,
  output logic [PC_W-1:0] PC_out,
  output logic [15:0]     IROut,
  output logic [3:0]      CurrentStateOut,
  output logic [3:0]      NextStateOut,
  output logic            Halted,
  output logic            IllegalOp
);

  state_e          state;
  state_e          next_state;
  logic [15:0]     ir;
  logic [3:0]      opcode;
  logic [PC_W-1:0] pc;
  logic            pc_load;
  logic            pc_inc;

  assign opcode = ir[15:12];

  // Next-state logic; Reset overrides every transition.
  always_comb begin
    next_state = state;
    case (state)
      ST_INIT:  next_state = ST_FETCH;
      ST_FETCH: if (IMem_valid) next_state = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_NOOP:  next_state = ST_FETCH;
          OP_LOAD:  next_state = ST_LOAD_A;
          OP_STORE: next_state = ST_STORE;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: next_state = ST_ALU;
          OP_JMP:   next_state = ST_JUMP;
          OP_BRZ:   next_state = ST_BRZ_EVAL;
          default:  next_state = ST_HALT;
        endcase
      end
      ST_LOAD_A:   next_state = ST_LOAD_B;
      ST_LOAD_B,
      ST_STORE,
      ST_ALU,
      ST_JUMP,
      ST_BRZ_EVAL: next_state = ST_FETCH;
      ST_HALT:     next_state = ST_HALT;
      default:     next_state = ST_INIT;
    endcase
    if (Reset) next_state = ST_INIT;
  end

  // PC control: increment on accepted fetch, load on jump or taken branch.
  always_comb begin
    pc_inc  = (state == ST_FETCH) && IMem_valid;
    pc_load = (state == ST_JUMP) || ((state == ST_BRZ_EVAL) && ALU_zero);
  end

  pc_counter #(
    .PC_W(PC_W)
  ) u_pc (
    .clk      (Clock),
    .rst      (Reset),
    .reset_vec(RESET_VEC),
    .load     (pc_load),
    .load_val (ir[PC_W-1:0]),
    .inc      (pc_inc),
    .pc       (pc)
  );

  assign IMem_addr       = pc;
  assign PC_out          = pc;
  assign IROut           = ir;
  assign CurrentStateOut = state;
  assign NextStateOut    = next_state;

  // State, IR, sticky flag and outputs. Outputs are decoded from next_state
  // so they are registered yet valid during the state they belong to; IR is
  // already stable whenever a state that uses its fields is being entered.
  always_ff @(posedge Clock) begin
    IMem_req   <= 1'b0;
    D_addr     <= '0;
    D_wr       <= 1'b0;
    RF_s       <= 1'b0;
    RF_W_addr  <= '0;
    RF_Ra_addr <= '0;
    RF_Rb_addr <= '0;
    RF_W_en    <= 1'b0;
    ALU_s0     <= '0;
    Halted     <= 1'b0;
    if (Reset) begin
      state     <= ST_INIT;
      ir        <= '0;
      IllegalOp <= 1'b0;
    end else begin
      state <= next_state;
      if (pc_inc) ir <= IMem_data;
      if ((state == ST_DECODE) && !is_legal_op(opcode)) IllegalOp <= 1'b1;
      case (next_state)
        ST_FETCH: IMem_req <= 1'b1;
        ST_LOAD_A: begin
          D_addr <= ir[11:4];
          RF_s   <= 1'b1;
        end
        ST_LOAD_B: begin
          D_addr    <= ir[11:4];
          RF_s      <= 1'b1;
          RF_W_en   <= 1'b1;
          RF_W_addr <= ir[3:0];
        end
        ST_STORE: begin
          D_addr     <= ir[11:4];
          RF_Ra_addr <= ir[3:0];
          D_wr       <= 1'b1;
        end
        ST_ALU: begin
          RF_Ra_addr <= ir[11:8];
          RF_Rb_addr <= ir[7:4];
          ALU_s0     <= alu_sel(opcode);
          RF_W_en    <= 1'b1;
          RF_W_addr  <= ir[3:0];
        end
        ST_BRZ_EVAL: RF_Ra_addr <= ir[11:8];
        ST_HALT:     Halted <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
